// File: rtl/parallel_cnt7_pkg.sv
// parallel_cnt7_pkg: shared widths and the count type for the 7:3 population counter.
package parallel_cnt7_pkg;
    localparam int CNT_W = 3;
    localparam int IN_W  = 7;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/parallel_cnt7_full_adder.sv
// full_adder: single-bit combinational full adder, the building block of the 7:3 compressor.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/parallel_cnt7.sv
// parallel_cnt7: 7:3 full-adder popcount with a registered copy and a wrapping running accumulator.
module parallel_cnt7
    import parallel_cnt7_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             in_vld,
    input  logic             acc_en,
    input  logic             acc_clr,
    output cnt_t             out,
    output cnt_t             out_q,
    output logic             out_vld,
    output logic [ACC_W-1:0] acc
);
    logic sum_a, carry_a, sum_b, carry_b, carry_c;
    full_adder fa_a (.a(in[0]), .b(in[1]), .ci(in[2]), .s(sum_a), .co(carry_a));
    full_adder fa_b (.a(in[3]), .b(in[4]), .ci(in[5]), .s(sum_b), .co(carry_b));
    full_adder fa_c (.a(sum_a), .b(sum_b), .ci(in[6]), .s(out[0]), .co(carry_c));
    // The three weight-2 carries fold into bits 1 and 2 of the count.
    full_adder fa_d (.a(carry_a), .b(carry_b), .ci(carry_c), .s(out[1]), .co(out[2]));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_q   <= '0;
            out_vld <= 1'b0;
            acc     <= '0;
        end else begin
            out_q   <= out;
            out_vld <= in_vld;
            acc     <= acc_clr ? '0 : (acc_en && in_vld) ? acc + {{(ACC_W-CNT_W){1'b0}}, out} : acc;
        end
endmodule

// File: tb/tb_parallel_cnt7.sv
// tb_parallel_cnt7: vector table, exhaustive sweep, corner sequences and randomized check vs a popcount model.
module tb_parallel_cnt7;
    logic clk, rst, in_vld, acc_en, acc_clr;
    logic [6:0] in;
    logic [2:0] out, out_q, out4, out_q4;
    logic out_vld, out_vld4;
    logic [15:0] acc;
    logic [3:0] acc4;
    int total = 0, bad = 0;

    parallel_cnt7 #(.ACC_W(16)) dut (.clk(clk), .rst(rst), .in(in), .in_vld(in_vld), .acc_en(acc_en),
        .acc_clr(acc_clr), .out(out), .out_q(out_q), .out_vld(out_vld), .acc(acc));
    parallel_cnt7 #(.ACC_W(4)) dut4 (.clk(clk), .rst(rst), .in(in), .in_vld(in_vld), .acc_en(acc_en),
        .acc_clr(acc_clr), .out(out4), .out_q(out_q4), .out_vld(out_vld4), .acc(acc4));

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] in;
        logic [2:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] i, input logic v, input logic e, input logic c);
        in = i; in_vld = v; acc_en = e; acc_clr = c;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[7];
        int acc_m, acc4_m, q_m, v_m, cnt;
        tbl[0] = '{7'd1, 3'd1};
        tbl[1] = '{7'd2, 3'd1};
        tbl[2] = '{7'd3, 3'd2};
        tbl[3] = '{7'd127, 3'd7};
        tbl[4] = '{7'd65, 3'd2};
        tbl[5] = '{7'd0, 3'd0};
        tbl[6] = '{7'h40, 3'd1};

        rst = 1;
        drive(7'h55, 1, 1, 0);
        #2;
        chk("reset out_q", {29'd0, out_q}, 0);
        chk("reset out_vld", {31'd0, out_vld}, 0);
        chk("reset acc", {16'd0, acc}, 0);
        chk("reset out tracks in", {29'd0, out}, 4);

        // Same-cycle combinational count through the vector table.
        foreach (tbl[k]) begin
            in = tbl[k].in;
            #1;
            chk($sformatf("table out in=%0d", tbl[k].in), {29'd0, out}, {29'd0, tbl[k].exp});
        end
        @(negedge clk);
        rst = 0;

        // Exhaustive sweep: out immediately, out_q one edge later.
        for (int v = 0; v < 128; v++) begin
            @(negedge clk);
            drive(7'(v), 0, 0, 0);
            #1;
            chk($sformatf("sweep out in=%0d", v), {29'd0, out}, $countones(v));
            edge_step();
            chk($sformatf("sweep out_q in=%0d", v), {29'd0, out_q}, $countones(v));
        end

        // Accumulate 127 three times; 4-bit instance wraps 7,14,5.
        @(negedge clk);
        rst = 1;
        #1;
        rst = 0;
        drive(7'd127, 1, 1, 0);
        edge_step();
        chk("acc4 step1", {28'd0, acc4}, 7);
        edge_step();
        chk("acc4 step2", {28'd0, acc4}, 14);
        edge_step();
        chk("acc4 step3 wrap", {28'd0, acc4}, 5);
        chk("acc after 3x127", {16'd0, acc}, 21);
        drive(7'd127, 1, 1, 1);
        edge_step();
        chk("acc_clr priority", {16'd0, acc}, 0);

        // Hold when in_vld is low.
        drive(7'd127, 1, 1, 0);
        edge_step();
        drive(7'd127, 0, 1, 0);
        edge_step();
        chk("hold acc", {16'd0, acc}, 7);
        chk("hold out_vld", {31'd0, out_vld}, 0);

        // Async reset mid-cycle while acc is non-zero.
        drive(7'd3, 1, 1, 0);
        #2;
        rst = 1;
        #1;
        chk("async acc", {16'd0, acc}, 0);
        chk("async out_q", {29'd0, out_q}, 0);
        chk("async out_vld", {31'd0, out_vld}, 0);
        chk("async out tracks in", {29'd0, out}, 2);
        in = 7'h7F;
        #1;
        chk("async out follows", {29'd0, out}, 7);
        @(negedge clk);
        rst = 0;
        edge_step();
        chk("resume from 0", {16'd0, acc}, 7);

        // Randomized run against a popcount/modular-sum model.
        @(negedge clk);
        rst = 1;
        #1;
        rst = 0;
        acc_m = 0; acc4_m = 0; q_m = 0; v_m = 0;
        for (int n = 0; n < 400; n++) begin
            drive(7'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            cnt = $countones(in);
            #1;
            chk("rand out", {29'd0, out}, cnt);
            edge_step();
            q_m = cnt;
            v_m = int'(in_vld);
            if (acc_clr) begin
                acc_m = 0;
                acc4_m = 0;
            end else if (acc_en && in_vld) begin
                acc_m = (acc_m + cnt) % 65536;
                acc4_m = (acc4_m + cnt) % 16;
            end
            chk("rand out_q", {29'd0, out_q}, q_m);
            chk("rand out_vld", {31'd0, out_vld}, v_m);
            chk("rand acc", {16'd0, acc}, acc_m);
            chk("rand acc4", {28'd0, acc4}, acc4_m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parallel_cnt7.md
PARALLEL_CNT7 -- requirements
Module: parallel_cnt7

Interface
REQ-001 The parameter list SHALL be: ACC_W, default 16, width of the running population accumulator (minimum 3).
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock, with all state on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 The port in SHALL be an input, 7 bits wide: the bit vector to be counted.
REQ-005 The port in_vld SHALL be an input, 1 bit wide: qualifies in for the registered path and the accumulator.
REQ-006 The port acc_en SHALL be an input, 1 bit wide: adds the current count into acc when asserted with in_vld.
REQ-007 The port acc_clr SHALL be an input, 1 bit wide: synchronous clear of acc.
REQ-008 The port out SHALL be an output, 3 bits wide: combinational count of ones in in.
REQ-009 The port out_q SHALL be an output, 3 bits wide: registered copy of out.
REQ-010 The port out_vld SHALL be an output, 1 bit wide: registered copy of in_vld, aligned with out_q.
REQ-011 The port acc SHALL be an output, ACC_W bits wide: the running sum of counts.

Function
REQ-012 out SHALL equal the number of 1 bits in in (range 0..7), purely combinational, with zero cycles of latency and no dependence on clk, rst or in_vld.
REQ-013 out SHALL be built as a 7:3 full-adder compressor:
- FA_a(in[0],in[1],in[2]) and FA_b(in[3],in[4],in[5]).
- FA_c(sum_a,sum_b,in[6]) gives out[0].
- FA_d(carry_a,carry_b,carry_c) gives out[1]=sum_d and out[2]=carry_d.
REQ-014 Each rising clk edge, out_q SHALL load out and out_vld SHALL load in_vld, giving exactly 1 cycle of latency.
REQ-015 out_q SHALL update every cycle regardless of in_vld; consumers qualify it with out_vld.
REQ-016 On each rising edge, acc SHALL update as follows:
- acc_clr=1: acc becomes 0.
- Otherwise, acc_en=1 and in_vld=1: acc becomes acc + out (zero-extended).
- Otherwise: acc holds.
REQ-017 acc_clr SHALL take priority over acc_en when both are asserted in the same cycle; that cycle's count is discarded.
REQ-018 The acc addition SHALL wrap modulo 2^ACC_W, with no saturation and no overflow flag.
REQ-019 in=0 SHALL give out=0, and in=7'h7F SHALL give out=7; no input value SHALL produce an X or out-of-range result.

Reset
REQ-020 While rst=1, out_q, out_vld and acc SHALL be 0, asynchronously and without waiting for a clk edge.
REQ-021 out SHALL remain combinational during reset and continue to reflect in.
REQ-022 When rst is asserted mid-accumulation, acc SHALL return to 0 and SHALL resume from 0 on the first clk edge after deassertion.

Structure
REQ-023 A shared package SHALL hold the constants CNT_W=3 and IN_W=7 and a count typedef of CNT_W bits.
REQ-024 One sub-module, full_adder (inputs a, b, ci; outputs s, co; combinational), SHALL be instantiated four times.
REQ-025 The registered output path and the accumulator SHALL reside in parallel_cnt7.

Verification
REQ-026 The bench SHALL drive in = 1, 2, 3, 127, 65 in sequence and require out = 1, 1, 2, 7, 2 within the same cycle.
REQ-027 The bench SHALL drive all 128 values of in exhaustively and require out to equal the reference popcount for each, and out_q to equal that value one cycle later.
REQ-028 The bench SHALL, after reset with in_vld=acc_en=1, apply in=127 for 3 cycles and require acc to read 21, then apply acc_clr=1 together with acc_en=1 and require acc to read 0 on the next edge.
REQ-029 The bench SHALL, with ACC_W=4 and in=127 with accumulation enabled, require acc to step through 7, 14, 5 (wrap at 16).
REQ-030 The bench SHALL assert rst asynchronously between clk edges while acc is non-zero and require acc, out_q and out_vld to drop to 0 immediately while out still tracks in.
REQ-031 The bench SHALL, with in_vld=0 and acc_en=1, require acc to hold its value and out_vld to read 0 one cycle later.
